dmem_arbiter: RTL

//  Two-requester arbiter and sequencer in front of the single-ported data memory (data_mem).

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (C pipeline, X external) arbiter/sequencer in front of single-ported data_mem
// Ports: clk_i/reset_i (sync, active-high); c_* and x_* request bundles (req, we, width_src, addr, wdata),
//   x_lock_i keeps X ownership across beats; responses gnt/rvalid/rdata/err per port, c_stall_o to hazard unit;
//   mem_* drives data_mem combinationally, mem_rdata_i is its combinational read data.
// Optional: define DMEM_ARB_STARVE_GUARD_EN to force an X grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             c_req_i,
    input  logic             c_we_i,
    input  logic [1:0]       c_width_src_i,
    input  logic [WIDTH-1:0] c_addr_i,
    input  logic [WIDTH-1:0] c_wdata_i,
    output logic             c_gnt_o,
    output logic             c_stall_o,
    output logic             c_rvalid_o,
    output logic [WIDTH-1:0] c_rdata_o,
    output logic             c_err_o,
    input  logic             x_req_i,
    input  logic             x_we_i,
    input  logic [1:0]       x_width_src_i,
    input  logic [WIDTH-1:0] x_addr_i,
    input  logic [WIDTH-1:0] x_wdata_i,
    input  logic             x_lock_i,
    output logic             x_gnt_o,
    output logic             x_rvalid_o,
    output logic [WIDTH-1:0] x_rdata_o,
    output logic             x_err_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_width_src_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);
    typedef enum logic {S_IDLE, S_XLOCK} state_e;
    state_e state_q, state_d;
    logic c_gnt, x_gnt, force_x, fault, sel_we;
    logic [1:0] sel_w;
    logic [WIDTH-1:0] sel_a, sel_d;
    logic c_rvalid_q, c_err_q, x_rvalid_q, x_err_q;
    logic [WIDTH-1:0] c_rdata_q, x_rdata_q;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q, wait_d;
    assign force_x = (state_q == S_IDLE) && x_req_i && (wait_q == WW'(MAX_WAIT));
    // saturating count of consecutive denied X cycles
    always_comb wait_d = (!x_req_i || x_gnt) ? '0 : (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    always_ff @(posedge clk_i) wait_q <= reset_i ? '0 : wait_d;
`else
    logic unused_max_wait;
    assign force_x = 1'b0;
    assign unused_max_wait = ^MAX_WAIT;
`endif
    always_comb begin
        c_gnt   = 1'b0;
        x_gnt   = 1'b0;
        state_d = state_q;
        if (state_q == S_XLOCK) begin
            // the release cycle is still X-owned
            x_gnt = x_req_i;
            if (!x_lock_i || !x_req_i) state_d = S_IDLE;
        end else begin
            c_gnt = c_req_i & ~force_x;
            x_gnt = x_req_i & (~c_req_i | force_x);
            if (x_gnt && x_lock_i) state_d = S_XLOCK;
        end
    end
    assign sel_we = x_gnt ? x_we_i : c_gnt & c_we_i;
    assign sel_w  = x_gnt ? x_width_src_i : c_gnt ? c_width_src_i : 2'b00;
    assign sel_a  = x_gnt ? x_addr_i : c_gnt ? c_addr_i : '0;
    assign sel_d  = x_gnt ? x_wdata_i : c_gnt ? c_wdata_i : '0;
    // idle bus is all-zero, which decodes as an aligned word and never faults
    assign fault = (sel_w == 2'b11) | ((sel_w == 2'b10) & sel_a[0]) | ((sel_w == 2'b00) & (|sel_a[1:0]));
    assign mem_we_o        = sel_we & ~fault;
    assign mem_width_src_o = sel_w;
    assign mem_addr_o      = sel_a;
    assign mem_wdata_o     = sel_d;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            c_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            x_rvalid_q <= 1'b0;
            x_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            x_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            c_rvalid_q <= c_gnt & ~c_we_i & ~fault;
            c_err_q    <= c_gnt & fault;
            x_rvalid_q <= x_gnt & ~x_we_i & ~fault;
            x_err_q    <= x_gnt & fault;
            if (c_gnt & ~c_we_i & ~fault) c_rdata_q <= mem_rdata_i;
            if (x_gnt & ~x_we_i & ~fault) x_rdata_q <= mem_rdata_i;
        end
    end
    assign c_gnt_o    = c_gnt;
    assign x_gnt_o    = x_gnt;
    assign c_stall_o  = c_req_i & ~c_gnt;
    assign c_rvalid_o = c_rvalid_q;
    assign c_err_o    = c_err_q;
    assign c_rdata_o  = c_rdata_q;
    assign x_rvalid_o = x_rvalid_q;
    assign x_err_o    = x_err_q;
    assign x_rdata_o  = x_rdata_q;
endmodule
